// File: rtl/add_chunked_if.sv
// Operand/result handshake bundle for add_chunked.
// master drives operands and out_ready; slave is the adder.
interface add_chunked_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/add_chunked.sv
// Multi-cycle add/sub, CHUNK bits per cycle, LSB first.
// Ports: clk, rst_n (sync, active-low), bus (add_chunked_if.slave).
module add_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  add_chunked_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [KW-1:0]    k;
  logic             last;
  logic [CHUNK:0]   psum;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  assign last = (k == KW'(N - 1));

  always_comb begin
    psum = {1'b0, ra[k*CHUNK +: CHUNK]}
         + {1'b0, rb[k*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, carry};
  end

  // Full result as it will look once this chunk lands
  always_comb begin
    res = acc;
    res[k*CHUNK +: CHUNK] = psum[CHUNK-1:0];
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) nxt = RUN;
      end
      RUN: begin
        if (last) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ra    <= bus.a;
            rb    <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? ~bus.cin : bus.cin;
            acc   <= '0;
            k     <= '0;
          end
        end
        RUN: begin
          acc   <= res;
          carry <= psum[CHUNK];
          k     <= k + KW'(1);
          if (last) begin
            sum_q  <= res;
            cout_q <= psum[CHUNK];
            // a^b^s at the MSB recovers the carry into it
            ovf_q  <= ra[WIDTH-1] ^ rb[WIDTH-1]
                    ^ res[WIDTH-1] ^ psum[CHUNK];
            zero_q <= (res == '0);
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_add_chunked.sv
// Scoreboard bench for add_chunked.
// Two instances: CHUNK=4 and CHUNK=16, both WIDTH=16.
module tb_add_chunked;
  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errs;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;
  logic pv1;
  logic pv2;
  logic [18:0] h1;
  logic [18:0] h2;

  add_chunked_if #(.WIDTH(16)) i1 ();
  add_chunked_if #(.WIDTH(16)) i2 ();

  add_chunked #(.WIDTH(16), .CHUNK(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1)
  );
  add_chunked #(.WIDTH(16), .CHUNK(16)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(i2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  initial begin
    pv1 = 1'b0;
    pv2 = 1'b0;
    h1  = '0;
    h2  = '0;
  end

  always @(negedge clk) begin
    if (rst_n && i1.out_valid) begin
      if (!pv1) begin
        if (q1.size() == 0) begin
          chk("unexpected_out1", {13'd0, i1.sum, i1.out_valid, 2'b0}, 32'd0);
        end else begin
          e1 = q1.pop_front();
          chk("sum1", {16'd0, i1.sum}, {16'd0, e1.sum});
          chk("cout1", {31'd0, i1.cout}, {31'd0, e1.cout});
          chk("ovf1", {31'd0, i1.ovf}, {31'd0, e1.ovf});
          chk("zero1", {31'd0, i1.zero}, {31'd0, e1.zero});
          chk("lat1", cyc - e1.acc, 32'd4);
        end
      end else begin
        chk("hold1", {13'd0, i1.sum, i1.cout, i1.ovf, i1.zero},
            {13'd0, h1});
      end
    end
    pv1 <= i1.out_valid;
    h1  <= {i1.sum, i1.cout, i1.ovf, i1.zero};
  end

  always @(negedge clk) begin
    if (rst_n && i2.out_valid) begin
      if (!pv2) begin
        if (q2.size() == 0) begin
          chk("unexpected_out2", {13'd0, i2.sum, i2.out_valid, 2'b0}, 32'd0);
        end else begin
          e2 = q2.pop_front();
          chk("sum2", {16'd0, i2.sum}, {16'd0, e2.sum});
          chk("cout2", {31'd0, i2.cout}, {31'd0, e2.cout});
          chk("ovf2", {31'd0, i2.ovf}, {31'd0, e2.ovf});
          chk("zero2", {31'd0, i2.zero}, {31'd0, e2.zero});
          chk("lat2", cyc - e2.acc, 32'd1);
        end
      end
    end
    pv2 <= i2.out_valid;
    h2  <= {i2.sum, i2.cout, i2.ovf, i2.zero};
  end

  task automatic drive(int d, logic v, logic [15:0] a, logic [15:0] b,
                       logic s, logic c);
    if (d == 0) begin
      i1.in_valid = v; i1.a = a; i1.b = b; i1.sub = s; i1.cin = c;
    end else begin
      i2.in_valid = v; i2.a = a; i2.b = b; i2.sub = s; i2.cin = c;
    end
  endtask

  task automatic send(int d, logic [15:0] a, logic [15:0] b, logic s,
                      logic c, logic push, logic [15:0] es,
                      logic ec, logic eo, logic ez);
    exp_t e;
    int   n;
    logic rdy;
    @(negedge clk);
    drive(d, 1'b1, a, b, s, c);
    n = 0;
    rdy = (d == 0) ? i1.in_ready : i2.in_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = (d == 0) ? i1.in_ready : i2.in_ready;
    end
    if (!rdy) begin
      errs++;
      $display("FAIL accept_timeout dut=%0d actual=0 required=1", d);
    end
    @(posedge clk);
    #1;
    e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.acc = cyc;
    if (push && rdy) begin
      if (d == 0) q1.push_back(e);
      else q2.push_back(e);
    end
    drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while (((d == 0) ? q1.size() : q2.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      errs++;
      $display("FAIL drain_timeout dut=%0d actual=pending required=empty", d);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    checks = 0;
    errs   = 0;
    rst_n  = 1'b0;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    i1.out_ready = 1'b1;
    i2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, i1.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, i1.out_valid}, 32'd0);
    chk("rst_flags", {13'd0, i1.sum, i1.cout, i1.ovf, i1.zero}, 32'd0);
    chk("rst_in_ready2", {31'd0, i2.in_ready}, 32'd1);

    send(0, 16'h1234, 16'h0FED, 1'b0, 1'b0, 1'b1, 16'h2221, 0, 0, 0);
    drain(0);
    send(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1, 0, 1);
    drain(0);
    send(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1, 1, 0);
    drain(0);
    send(0, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8000, 0, 1, 0);
    drain(0);
    send(0, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0001, 1, 0, 0);
    drain(0);
    send(0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFFFF, 0, 0, 0);
    drain(0);

    i1.out_ready = 1'b0;
    send(0, 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b1, 16'hFFFF, 0, 0, 0);
    n = 0;
    while (!i1.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!i1.out_valid) begin
      errs++;
      $display("FAIL stall_wait actual=0 required=1");
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      @(negedge clk);
      chk("stall_out_valid", {31'd0, i1.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, i1.in_ready}, 32'd0);
      chk("stall_sum", {16'd0, i1.sum}, 32'h0000FFFF);
    end
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    i1.out_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", {31'd0, i1.in_ready}, 32'd1);
    chk("post_out_valid", {31'd0, i1.out_valid}, 32'd0);
    drain(0);

    send(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, i1.out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, i1.in_ready}, 32'd1);
    chk("abort_sum", {16'd0, i1.sum}, 32'd0);
    repeat (6) @(negedge clk);
    send(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0007, 0, 0, 0);
    drain(0);

    send(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 0, 0, 0);
    drain(1);
    send(1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1, 1, 1);
    drain(1);

    if (q1.size() != 0 || q2.size() != 0) begin
      errs++;
      $display("FAIL leftover actual=%0d required=0", q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/add_chunked.md
ADD_CHUNKED -- requirements
Module: add_chunked

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (>=2).
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be a multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 SHALL have port cin  input  1  carry-in (add) / borrow-in (sub).
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port zero  output  1  sum == 0.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 IDLE: on in_valid && in_ready, SHALL latch a, b' = sub ? ~b : b, carry = sub ? ~cin : cin, clear chunk counter, go RUN.
REQ-019 Add result SHALL equal a + b + cin; sub result SHALL equal a - b - cin, both mod 2^WIDTH.
REQ-020 RUN: each cycle SHALL add chunk k (LSB first, bits k*CHUNK+CHUNK-1..k*CHUNK) of a and b' plus stored carry, store the CHUNK-bit partial and carry-out, increment k.
REQ-021 After chunk N-1, SHALL load sum, cout, ovf, zero result registers and go DONE; out_valid high exactly N edges after the accepting edge.
REQ-022 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-023 DONE: sum/cout/ovf/zero/out_valid SHALL hold stable until out_valid && out_ready; then go IDLE (in_ready high next cycle).
REQ-024 in_valid SHALL be ignored in RUN and DONE; operands changing during RUN SHALL not affect the result.
REQ-025 sum/cout/ovf/zero SHALL change only at the RUN->DONE edge and at reset; partial sums SHALL never appear on sum.
REQ-026 CHUNK == WIDTH SHALL give N = 1 (single RUN cycle); throughput SHALL be one operation per N+2 cycles minimum.

Reset
REQ-027 rst_n low at a rising edge SHALL force IDLE from any state, aborting any operation in progress.
REQ-028 After reset: in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0, counter = 0, carry = 0.
REQ-029 An aborted operation SHALL produce no output; the next accepted operation SHALL compute correctly.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-030 Add 0x1234 + 0x0FED, cin=0 -> sum=0x2221, cout=0, ovf=0, zero=0, out_valid exactly 4 edges after accept.
REQ-031 Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1.
REQ-032 Sub 0x8000 - 0x0001, cin=0 -> sum=0x7FFF, cout=1, ovf=1; add 0x7FFF + 0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> out_valid, sum, flags stable, in_ready=0, new operands not accepted.
REQ-034 Assert rst_n=0 for one edge after 2 RUN chunks -> next cycle out_valid=0, in_ready=1, sum=0; following add 0x0003 + 0x0004 -> sum=0x0007.
REQ-035 CHUNK=16: add 0x00FF + 0x0001 -> sum=0x0100, out_valid 1 edge after accept.
